hub75_bcm_scheduler: RTL and testbench

//  Sequences a HUB75 panel with binary-coded modulation (BCM): for each row, for

---
 rtl/hub75_bcm_scheduler_if.sv | 26 ++
 rtl/hub75_bcm_scheduler.sv | 179 +++++++++++++++++
 tb/tb_hub75_bcm_scheduler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/hub75_bcm_scheduler_if.sv
// Framebuffer-side port of the HUB75 BCM scheduler: pixel read address, display bank
// select, writer swap handshake and the frame-start marker.
interface hub75_bcm_scheduler_if #(
   parameter int unsigned COLS = 64,
   parameter int unsigned BITS = 3
);
   localparam int unsigned COL_W   = $clog2(COLS);
   localparam int unsigned PLANE_W = (BITS > 1) ? $clog2(BITS) : 1;

   logic [COL_W-1:0]   col;
   logic [PLANE_W-1:0] plane;
   logic               front_sel;
   logic               swap_req;
   logic               swap_ack;
   logic               frame_start;

   modport master (
      output col, plane, front_sel, swap_ack, frame_start,
      input  swap_req
   );

   modport slave (
      input  col, plane, front_sel, swap_ack, frame_start,
      output swap_req
   );
endinterface

// File: rtl/hub75_bcm_scheduler.sv
// HUB75 binary-coded-modulation scan sequencer: shift, latch, weighted OE-low show per
// bit-plane per row, with frame-boundary bank swap. Define BLANK_GAP_EN for a post-row blank.
module hub75_bcm_scheduler #(
   parameter int unsigned COLS      = 64,
   parameter int unsigned ROWS      = 16,
   parameter int unsigned BITS      = 3,
   parameter int unsigned BLANK_TKS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick,
   input  logic [7:0]            brightness,
   hub75_bcm_scheduler_if.master fb,
   output logic [3:0]            ADDR,
   output logic                  clk_out,
   output logic                  LATCH,
   output logic                  OE
);
   localparam int unsigned COL_W   = $clog2(COLS);
   localparam int unsigned PLANE_W = (BITS > 1) ? $clog2(BITS) : 1;

`ifdef BLANK_GAP_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif
   localparam int unsigned GAP_TKS = GAP_EN ? BLANK_TKS : 0;

   typedef enum logic [2:0] {
      SHIFT,
      LATCH_ST,
      SHOW,
      NEXT,
      BLANK
   } state_t;

   state_t             state_q, state_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [PLANE_W-1:0] plane_q, plane_d;
   logic [3:0]         addr_q, addr_d;
   logic               clk_out_q, clk_out_d;
   logic               latch_q, latch_d;
   logic               oe_q, oe_d;
   logic               front_q, front_d;
   logic               ack_q, ack_d;
   logic               fs_q, fs_d;
   logic [15:0]        show_cnt_q, show_cnt_d;
   logic [7:0]         blank_cnt_q, blank_cnt_d;
   logic [15:0]        show_len;

   // NOTE: every signal gets its hold value first so no path through this block infers a latch.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      plane_d     = plane_q;
      addr_d      = addr_q;
      clk_out_d   = clk_out_q;
      latch_d     = latch_q;
      oe_d        = oe_q;
      front_d     = front_q;
      ack_d       = 1'b0;
      fs_d        = 1'b0;
      show_cnt_d  = show_cnt_q;
      blank_cnt_d = blank_cnt_q;
      show_len    = 16'(brightness) << plane_q;

      if (tick) begin
         case (state_q)
            SHIFT: begin
               if (!clk_out_q) begin
                  clk_out_d = 1'b1;
                  // First rising shift edge of row 0, plane 0 marks the frame start.
                  fs_d = (col_q == '0) && (plane_q == '0) && (addr_q == '0);
               end else begin
                  clk_out_d = 1'b0;
                  if (col_q == COL_W'(COLS - 1)) begin
                     state_d = LATCH_ST;
                     latch_d = 1'b1;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
            end

            LATCH_ST: begin
               latch_d    = 1'b0;
               show_cnt_d = show_len;
               oe_d       = (show_len == 16'd0);
               state_d    = SHOW;
            end

            SHOW: begin
               if (show_cnt_q <= 16'd1) begin
                  oe_d       = 1'b1;
                  show_cnt_d = 16'd0;
                  state_d    = NEXT;
               end else begin
                  show_cnt_d = show_cnt_q - 16'd1;
               end
            end

            NEXT: begin
               col_d   = '0;
               state_d = SHIFT;
               if (plane_q != PLANE_W'(BITS - 1)) begin
                  plane_d = plane_q + 1'b1;
               end else begin
                  plane_d = '0;
                  if (addr_q == 4'(ROWS - 1)) begin
                     addr_d = 4'd0;
                     if (fb.swap_req) begin
                        front_d = ~front_q;
                        ack_d   = 1'b1;
                     end
                  end else begin
                     addr_d = addr_q + 4'd1;
                  end
                  if (GAP_TKS != 0) begin
                     state_d     = BLANK;
                     blank_cnt_d = 8'(GAP_TKS);
                  end
               end
            end

            BLANK: begin
               if (blank_cnt_q <= 8'd1) begin
                  blank_cnt_d = 8'd0;
                  state_d     = SHIFT;
               end else begin
                  blank_cnt_d = blank_cnt_q - 8'd1;
               end
            end

            default: state_d = SHIFT;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SHIFT;
         col_q       <= '0;
         plane_q     <= '0;
         addr_q      <= 4'd0;
         clk_out_q   <= 1'b0;
         latch_q     <= 1'b0;
         oe_q        <= 1'b1;
         front_q     <= 1'b0;
         ack_q       <= 1'b0;
         fs_q        <= 1'b0;
         show_cnt_q  <= 16'd0;
         blank_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         plane_q     <= plane_d;
         addr_q      <= addr_d;
         clk_out_q   <= clk_out_d;
         latch_q     <= latch_d;
         oe_q        <= oe_d;
         front_q     <= front_d;
         ack_q       <= ack_d;
         fs_q        <= fs_d;
         show_cnt_q  <= show_cnt_d;
         blank_cnt_q <= blank_cnt_d;
      end
   end

   assign fb.col         = col_q;
   assign fb.plane       = plane_q;
   assign fb.front_sel   = front_q;
   assign fb.swap_ack    = ack_q;
   assign fb.frame_start = fs_q;
   assign ADDR           = addr_q;
   assign clk_out        = clk_out_q;
   assign LATCH          = latch_q;
   assign OE             = oe_q;
endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Directed bench for hub75_bcm_scheduler: shift/latch/show timing, BCM widths, blanking,
// brightness sampling, async reset and frame-boundary swap handshake.
`timescale 1ns/1ps
module tb_hub75_bcm_scheduler;
   localparam int unsigned COLS      = 64;
   localparam int unsigned ROWS      = 16;
   localparam int unsigned BITS      = 3;
   localparam int unsigned BLANK_TKS = 2;
`ifdef BLANK_GAP_EN
   localparam int GAP_EXP = 2;
`else
   localparam int GAP_EXP = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick = 1'b0;
   logic [7:0] brightness = 8'd0;
   logic [3:0] ADDR;
   logic       clk_out, LATCH, OE;

   hub75_bcm_scheduler_if #(.COLS(COLS), .BITS(BITS)) fb ();

   hub75_bcm_scheduler #(
      .COLS(COLS), .ROWS(ROWS), .BITS(BITS), .BLANK_TKS(BLANK_TKS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .brightness(brightness), .fb(fb),
      .ADDR(ADDR), .clk_out(clk_out), .LATCH(LATCH), .OE(OE)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Observation state, updated once per clk at the falling edge.
   int plane_rises, last_rises, latch_cnt, oe_run, last_oe, oe_pulses, oe_low_total;
   int ack_clks, fs_clks;
   int viol = 0;
   int col_err = 0;
   logic       clk_out_p, latch_p, oe_p;
   logic [3:0] addr_p;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      plane_rises = 0; last_rises = 0; latch_cnt = 0; oe_run = 0; last_oe = 0;
      oe_pulses = 0; oe_low_total = 0; ack_clks = 0; fs_clks = 0;
      clk_out_p = clk_out; latch_p = LATCH; oe_p = OE; addr_p = ADDR;
   endtask

   // One clk: advance to the falling edge, toggle tick (high every 2nd clk), observe.
   task automatic step();
      @(negedge clk);
      tick = ~tick;
      if (clk_out && !clk_out_p) begin
         if (fb.col != 6'(plane_rises)) col_err++;
         plane_rises++;
      end
      if (LATCH && !latch_p) begin
         last_rises  = plane_rises;
         plane_rises = 0;
         latch_cnt++;
      end
      if (!OE) begin
         oe_run++;
         oe_low_total++;
         if (clk_out || LATCH) viol++;
      end else if (!oe_p) begin
         last_oe = oe_run;
         oe_run  = 0;
         oe_pulses++;
      end
      if (ADDR != addr_p && (!OE || !oe_p)) viol++;
      if (fb.swap_ack) ack_clks++;
      if (fb.frame_start) fs_clks++;
      clk_out_p = clk_out; latch_p = LATCH; oe_p = OE; addr_p = ADDR;
   endtask

   task automatic wait_oe_pulse(input string tag, input int exp_ticks);
      int p0;
      int n;
      p0 = oe_pulses;
      n  = 0;
      while (oe_pulses == p0 && n < 4000) begin step(); n++; end
      check(tag, (oe_pulses != p0) ? 32'(last_oe / 2) : 32'hffff_ffff, 32'(exp_ticks));
   endtask

   task automatic wait_addr(input string tag, input logic [3:0] a);
      int n;
      n = 0;
      while (ADDR != a && n < 20000) begin step(); n++; end
      check(tag, 32'(ADDR), 32'(a));
   endtask

   task automatic wait_oe_low();
      int n;
      n = 0;
      while (OE && n < 4000) begin step(); n++; end
      check("oe_low_reached", 32'(OE), 32'd0);
   endtask

   initial begin
      int n, w, d, o;
      fb.swap_req = 1'b0;
      brightness  = 8'd5;
      rst_n       = 1'b1;
      #1 rst_n    = 1'b0;
      clear_mon();
      repeat (4) step();
      check("reset_outputs",
            {OE, LATCH, clk_out, fb.front_sel, fb.swap_ack, fb.frame_start, ADDR, fb.plane, fb.col},
            {1'b1, 5'b0, 4'd0, 2'd0, 6'd0});
      rst_n = 1'b1;
      clear_mon();

      // First plane: 64 shift clocks, one latch tick, then OE low.
      n = 0;
      while (!LATCH && n < 1000) begin step(); n++; end
      check("latch_seen", 32'(LATCH), 32'd1);
      check("rises_before_latch", 32'(last_rises), 32'd64);
      check("oe_high_at_latch", 32'(OE), 32'd1);
      check("fs_after_reset", 32'(fs_clks), 32'd1);
      w = 0;
      while (LATCH && w < 10) begin step(); w++; end
      check("latch_width_clks", 32'(w), 32'd2);
      check("oe_low_after_latch", 32'(OE), 32'd0);
      check("row0_plane0", {ADDR, fb.plane}, {4'd0, 2'd0});

      // BCM weights for brightness 5: 5, 10, 20 ticks; row advances only after plane 2.
      wait_oe_pulse("show_plane0", 5);
      wait_oe_pulse("show_plane1", 10);
      check("plane1_addr0", {ADDR, fb.plane}, {4'd0, 2'd1});
      wait_oe_pulse("show_plane2", 20);
      check("addr_held_plane2", 32'(ADDR), 32'd0);
      n = 0;
      while (ADDR == 4'd0 && n < 100) begin step(); n++; end
      check("addr_advance", {ADDR, fb.plane}, {4'd1, 2'd0});
      d = 0; o = 0;
      while (!clk_out && d < 100) begin
         step(); d++;
         if (!OE) o++;
      end
      check("gap_ticks", 32'((d - 2) / 2), 32'(GAP_EXP));
      check("gap_oe_high", 32'(o), 32'd0);

      // Brightness changed mid-SHOW applies only from the next SHOW (3 << 1 = 6).
      wait_oe_low();
      brightness = 8'd3;
      wait_oe_pulse("bright_mid_show", 5);
      wait_oe_pulse("bright_next_show", 6);

      // Async reset during SHOW of row 1, plane 2.
      wait_oe_low();
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            {OE, LATCH, clk_out, fb.front_sel, fb.swap_ack, fb.frame_start, ADDR, fb.plane, fb.col},
            {1'b1, 5'b0, 4'd0, 2'd0, 6'd0});
      clear_mon();
      repeat (3) step();
      brightness = 8'd0;
      rst_n = 1'b1;
      clear_mon();
      repeat (20) step();
      check("fs_after_release", 32'(fs_clks), 32'd1);

      // Frame A: brightness 0, swap requested at row 7 -> swap at wrap.
      wait_addr("row7_a", 4'd7);
      fb.swap_req = 1'b1;
      wait_addr("row15_a", 4'd15);
      wait_addr("wrap_a", 4'd0);
      repeat (4) step();
      check("b0_oe_never_low", 32'(oe_low_total), 32'd0);
      check("b0_latches", 32'(latch_cnt), 32'd48);
      check("swap_a_ack", 32'(ack_clks), 32'd1);
      check("swap_a_front", 32'(fb.front_sel), 32'd1);
      check("fs_two_frames", 32'(fs_clks), 32'd2);

      // Frame B: request held -> second swap.
      wait_addr("row15_b", 4'd15);
      wait_addr("wrap_b", 4'd0);
      repeat (4) step();
      check("swap_b_ack", 32'(ack_clks), 32'd2);
      check("swap_b_front", 32'(fb.front_sel), 32'd0);

      // Frame C: request dropped at row 3 -> no swap.
      wait_addr("row3_c", 4'd3);
      fb.swap_req = 1'b0;
      wait_addr("row15_c", 4'd15);
      wait_addr("wrap_c", 4'd0);
      repeat (4) step();
      check("swap_c_ack", 32'(ack_clks), 32'd2);
      check("swap_c_front", 32'(fb.front_sel), 32'd0);
      check("latches_3_frames", 32'(latch_cnt), 32'd144);
      check("fs_four_frames", 32'(fs_clks), 32'd4);

      check("oe_low_violations", 32'(viol), 32'd0);
      check("col_sequence_errors", 32'(col_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
